// File: rtl/star_ni_pkg.sv
// Shared types and sizing helpers for the star NoC endpoint interface.
// The header struct describes the default (NE=8, MAX_LEN=16) layout.
package star_ni_pkg;

   function automatic int eaw_f(input int ne);
      return ($clog2(ne) < 1) ? 1 : $clog2(ne);
   endfunction

   function automatic int lw_f(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   localparam int NE_DEF      = 8;
   localparam int MAX_LEN_DEF = 16;
   localparam int EAW_DEF     = eaw_f(NE_DEF);
   localparam int LW_DEF      = lw_f(MAX_LEN_DEF);

   typedef struct packed {
      logic [LW_DEF-1:0]  len;
      logic [EAW_DEF-1:0] src;
      logic [EAW_DEF-1:0] dest;
   } star_hdr_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_BODY
   } state_t;

endpackage

// File: rtl/star_credit_counter.sv
// Saturating credit counter tracking free slots in the router input buffer.
module star_credit_counter
   import star_ni_pkg::*;
#(
   parameter int B = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     inc,
   input  logic                     dec,
   output logic [$clog2(B+1)-1:0]   count,
   output logic                     has_credit
);

   localparam int            CW   = $clog2(B + 1);
   localparam logic [CW-1:0] FULL = CW'(B);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= FULL;
      end else begin
         case ({inc, dec})
            2'b10:   if (count != FULL) count <= count + 1'b1;
            2'b01:   if (count != '0)   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign has_credit = (count != '0);

   // A returned credit with no outstanding flit means the router over-reported.
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(inc && !dec && count == FULL));

endmodule

// File: rtl/star_endpoint_injector.sv
// Endpoint transmitter: validates a (dest, len) request and emits header/body/tail
// flits toward the star router under credit flow control.
module star_endpoint_injector
   import star_ni_pkg::*;
#(
   parameter int NE      = 8,
   parameter int Fw      = 32,
   parameter int MAX_LEN = 16,
   parameter int B       = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [eaw_f(NE)-1:0]      self_addr,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [eaw_f(NE)-1:0]      req_dest,
   input  logic [lw_f(MAX_LEN)-1:0]  req_len,
   input  logic                      wd_valid,
   output logic                      wd_ready,
   input  logic [Fw-1:0]             wd_data,
   output logic                      flit_wr,
   output logic                      flit_hdr,
   output logic                      flit_tail,
   output logic [Fw-1:0]             flit_data,
   input  logic                      credit_in,
   output logic                      req_err,
   output logic                      busy
);

   localparam int             EAW     = eaw_f(NE);
   localparam int             LW      = lw_f(MAX_LEN);
   localparam int             CW      = $clog2(B + 1);
   localparam logic [EAW:0]   NE_LIM  = (EAW+1)'(NE);
   localparam logic [LW-1:0]  LEN_MAX = LW'(MAX_LEN);

   state_t           state, state_n;
   logic [EAW-1:0]   dest_q;
   logic [LW-1:0]    len_q, cnt_q;
   logic [CW-1:0]    credits;
   logic             has_credit;
   logic             issue, issue_hdr, issue_tail, err_n, load, req_bad;
   logic [Fw-1:0]    issue_data, hdr_word;

   star_credit_counter #(.B(B)) u_credits (
      .clk        (clk),
      .reset      (reset),
      .inc        (credit_in),
      .dec        (issue),
      .count      (credits),
      .has_credit (has_credit)
   );

   // The router trusts dest blindly, so every bad address is caught here.
   assign req_bad = ({1'b0, req_dest} >= NE_LIM) || (req_dest == self_addr) ||
                    (req_len > LEN_MAX);

   always_comb begin
      hdr_word                    = '0;
      hdr_word[EAW-1:0]           = dest_q;
      hdr_word[2*EAW-1:EAW]       = self_addr;
      hdr_word[2*EAW+LW-1:2*EAW]  = len_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n    = state;
      req_ready  = 1'b0;
      wd_ready   = 1'b0;
      issue      = 1'b0;
      issue_hdr  = 1'b0;
      issue_tail = 1'b0;
      issue_data = '0;
      err_n      = 1'b0;
      load       = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_bad) begin
                  err_n = 1'b1;
               end else begin
                  load    = 1'b1;
                  state_n = ST_HDR;
               end
            end
         end
         ST_HDR: begin
            if (has_credit) begin
               issue      = 1'b1;
               issue_hdr  = 1'b1;
               issue_data = hdr_word;
               issue_tail = (len_q == '0);
               state_n    = (len_q == '0) ? ST_IDLE : ST_BODY;
            end
         end
         ST_BODY: begin
            wd_ready = has_credit;
            if (wd_valid && has_credit) begin
               issue      = 1'b1;
               issue_data = wd_data;
               issue_tail = (cnt_q == LW'(1));
               if (cnt_q == LW'(1)) state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (load) begin
         dest_q <= req_dest;
         len_q  <= req_len;
      end
      if (issue) cnt_q <= issue_hdr ? len_q : cnt_q - 1'b1;
   end

   // Output stage: flit decided this cycle is presented to the router next cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flit_wr   <= 1'b0;
         flit_hdr  <= 1'b0;
         flit_tail <= 1'b0;
         flit_data <= '0;
         req_err   <= 1'b0;
      end else begin
         flit_wr   <= issue;
         flit_hdr  <= issue_hdr;
         flit_tail <= issue_tail;
         flit_data <= issue_data;
         req_err   <= err_n;
      end
   end

   assign busy = (state != ST_IDLE);

   a_issue_has_credit: assert property (@(posedge clk) disable iff (!reset)
      issue |-> (credits != '0));

endmodule
